// File: rtl/sweep_pkg.sv
// Shared types and widths for the sweep readout stage that sits in front of `range`.
package sweep_pkg;

    localparam int COUNT_W = 16;
    localparam int N_W     = 32;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LOW,
        WAIT_DONE,
        READ,
        CAPTURE,
        STREAM,
        SUMMARY
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]   index;
        logic [N_W-1:0]     n;
        logic [COUNT_W-1:0] count;
        logic               last;
    } beat_t;

endpackage

// File: rtl/sweep_reader.sv
// Launches one `range` sweep, streams every count back out, then reports the
// largest count together with the n that produced it.
module sweep_reader
    import sweep_pkg::*;
#(
    parameter int RAM_WORDS      = 16,
    parameter int RAM_ADDR_BITS  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [N_W-1:0]           req_base,
    output logic                     rng_go,
    output logic [N_W-1:0]           rng_start,
    input  logic                     rng_done,
    input  logic [COUNT_W-1:0]       rng_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RAM_ADDR_BITS-1:0] out_index,
    output logic [N_W-1:0]           out_n,
    output logic [COUNT_W-1:0]       out_count,
    output logic                     out_last,
    output logic                     sum_valid,
    output logic [COUNT_W-1:0]       max_count,
    output logic [N_W-1:0]           max_n,
    output logic                     err,
    output state_t                   dbg_state
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; once valid is raised the payload holds until that edge.

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0]       TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RAM_ADDR_BITS-1:0] IDX_LAST   = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state;
    logic [RAM_ADDR_BITS-1:0] idx;
    logic [N_W-1:0]           base;
    logic [TIMER_W-1:0]       timer;
    logic                     last_q;
    logic                     timed_out;

    assign timed_out = (timer >= TIMER_LAST);

    // The read port is addressed by idx only while a word is being fetched.
    assign rng_start = (state == READ || state == CAPTURE) ? N_W'(idx) : base;
    assign out_last  = out_valid & last_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rng_go    <= 1'b0;
            out_valid <= 1'b0;
            sum_valid <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            base      <= '0;
            timer     <= '0;
            out_index <= '0;
            out_n     <= '0;
            out_count <= '0;
            last_q    <= 1'b0;
            max_count <= '0;
            max_n     <= '0;
        end else begin
            rng_go    <= 1'b0;
            sum_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        base      <= req_base;
                        idx       <= '0;
                        max_count <= '0;
                        max_n     <= '0;
                        timer     <= '0;
                        req_ready <= 1'b0;
                        rng_go    <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT_LOW;
                WAIT_LOW: begin
                    // A done still high from the previous sweep must drop first.
                    if (!rng_done) begin
                        timer <= timer + 1'b1;
                        state <= WAIT_DONE;
                    end else if (timed_out) begin
                        err       <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (rng_done) begin
                        state <= READ;
                    end else if (timed_out) begin
                        err       <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    out_index <= idx;
                    out_n     <= base + N_W'(idx);
                    out_count <= rng_count;
                    last_q    <= (idx == IDX_LAST);
                    // Strict compare keeps the lowest index on ties.
                    if (rng_count > max_count) begin
                        max_count <= rng_count;
                        max_n     <= base + N_W'(idx);
                    end
                    out_valid <= 1'b1;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == IDX_LAST) begin
                            sum_valid <= 1'b1;
                            state     <= SUMMARY;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= READ;
                        end
                    end
                end
                SUMMARY: begin
                    idx       <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
